// File: rtl/payout_pkg.sv
// Shared types and constants for the change-payout sequencer.
package payout_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_PULSE,
      ST_WAIT_ACK,
      ST_GAP,
      ST_DONE,
      ST_FAULT
   } payout_state_t;

   localparam int COIN_HI = 2;
   localparam int COIN_LO = 1;

   localparam int DEF_VAL_W       = 4;
   localparam int DEF_PULSE_CYC   = 3;
   localparam int DEF_GAP_CYC     = 2;
   localparam int DEF_ACK_TIMEOUT = 8;

   localparam int TMR_W = 8;

endpackage

// File: rtl/payout_timer.sv
// Loadable down-counter with a terminal-count flag, shared by all timed states.
module payout_timer
   import payout_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   output logic             zero
);

   logic [TMR_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/change_payout.sv
// Coin-return sequencer: pays an amount greedily from the 2- and 1-unit hoppers,
// one sensor-confirmed coin at a time, with timeout and empty-hopper faults.
//
//  state    | meaning
//  ---------+--------------------------------------------------------
//  IDLE     | waiting for start; remaining holds the last value
//  SELECT   | choose next coin from remaining and hopper flags
//  PULSE    | selected solenoid held high for PULSE_CYC cycles
//  WAIT_ACK | waiting up to ACK_TIMEOUT cycles for the exit sensor
//  GAP      | GAP_CYC idle cycles between coins
//  DONE     | one-cycle completion pulse
//  FAULT    | solenoids off, remaining frozen until clear
module change_payout
   import payout_pkg::*;
#(
   parameter int VAL_W       = DEF_VAL_W,
   parameter int PULSE_CYC   = DEF_PULSE_CYC,
   parameter int GAP_CYC     = DEF_GAP_CYC,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [VAL_W-1:0] amount,
   input  logic             empty2,
   input  logic             empty1,
   input  logic             coin_sensed,
   input  logic             clear,
   output logic             coin2_out,
   output logic             coin1_out,
   output logic             busy,
   output logic             done,
   output logic             fault,
   output logic [VAL_W-1:0] remaining
);

   payout_state_t    state;
   logic [VAL_W-1:0] coin_val;
   logic             tmr_load;
   logic [TMR_W-1:0] tmr_val;
   logic             tmr_zero;
   logic             tmr_expired;

   // The load is registered with the state change, so the timer is loaded
   // during the first cycle of each timed state; load values are N-2 and
   // each timed parameter must therefore be at least 2.
   assign tmr_expired = tmr_zero && !tmr_load;

   payout_timer u_timer (
      .clk      (clk),
      .rst_n    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         coin2_out <= 1'b0;
         coin1_out <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fault     <= 1'b0;
         remaining <= '0;
         coin_val  <= '0;
         tmr_load  <= 1'b0;
         tmr_val   <= '0;
      end else begin
         tmr_load <= 1'b0;
         done     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  remaining <= amount;
                  busy      <= 1'b1;
                  state     <= ST_SELECT;
               end
            end
            ST_SELECT: begin
               if (remaining == '0) begin
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else if (remaining >= VAL_W'(COIN_HI) && !empty2) begin
                  coin_val  <= VAL_W'(COIN_HI);
                  coin2_out <= 1'b1;
                  tmr_load  <= 1'b1;
                  tmr_val   <= TMR_W'(PULSE_CYC - 2);
                  state     <= ST_PULSE;
               end else if (!empty1) begin
                  coin_val  <= VAL_W'(COIN_LO);
                  coin1_out <= 1'b1;
                  tmr_load  <= 1'b1;
                  tmr_val   <= TMR_W'(PULSE_CYC - 2);
                  state     <= ST_PULSE;
               end else begin
                  fault <= 1'b1;
                  state <= ST_FAULT;
               end
            end
            ST_PULSE: begin
               if (tmr_expired) begin
                  coin2_out <= 1'b0;
                  coin1_out <= 1'b0;
                  tmr_load  <= 1'b1;
                  tmr_val   <= TMR_W'(ACK_TIMEOUT - 2);
                  state     <= ST_WAIT_ACK;
               end
            end
            ST_WAIT_ACK: begin
               if (coin_sensed) begin
                  remaining <= remaining - coin_val;
                  if (remaining == coin_val) begin
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     tmr_load <= 1'b1;
                     tmr_val  <= TMR_W'(GAP_CYC - 2);
                     state    <= ST_GAP;
                  end
               end else if (tmr_expired) begin
                  fault <= 1'b1;
                  state <= ST_FAULT;
               end
            end
            ST_GAP: begin
               if (tmr_expired) begin
                  state <= ST_SELECT;
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            ST_FAULT: begin
               if (clear) begin
                  fault <= 1'b0;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: begin
               coin2_out <= 1'b0;
               coin1_out <= 1'b0;
               busy      <= 1'b0;
               fault     <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_change_payout.sv
// Directed bench for change_payout with hand-computed cycle expectations.
module tb_change_payout;

   localparam int VAL_W       = 4;
   localparam int PULSE_CYC   = 3;
   localparam int GAP_CYC     = 2;
   localparam int ACK_TIMEOUT = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [VAL_W-1:0] amount = '0;
   logic             empty2 = 1'b0;
   logic             empty1 = 1'b0;
   logic             coin_sensed = 1'b0;
   logic             clear = 1'b0;
   logic             coin2_out, coin1_out, busy, done, fault;
   logic [VAL_W-1:0] remaining;

   int n_chk = 0;
   int n_err = 0;
   int done_cnt = 0;
   int overlap_cnt = 0;

   change_payout #(
      .VAL_W       (VAL_W),
      .PULSE_CYC   (PULSE_CYC),
      .GAP_CYC     (GAP_CYC),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .amount      (amount),
      .empty2      (empty2),
      .empty1      (empty1),
      .coin_sensed (coin_sensed),
      .clear       (clear),
      .coin2_out   (coin2_out),
      .coin1_out   (coin1_out),
      .busy        (busy),
      .done        (done),
      .fault       (fault),
      .remaining   (remaining)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (coin1_out && coin2_out) overlap_cnt++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_pay(input int amt);
      amount = VAL_W'(amt);
      start  = 1'b1;
      tick();
      start  = 1'b0;
      chk("sel_busy", int'(busy), 1);
      chk("sel_rem", int'(remaining), amt);
      chk("sel_coins", int'({coin2_out, coin1_out}), 0);
   endtask

   // Entered while observing a SELECT cycle; leaves in the next SELECT, or in DONE if last.
   task automatic do_coin(input int coin, input int rem_after, input bit last);
      for (int i = 0; i < PULSE_CYC; i++) begin
         tick();
         chk("pulse_c2", int'(coin2_out), (coin == 2) ? 1 : 0);
         chk("pulse_c1", int'(coin1_out), (coin == 1) ? 1 : 0);
      end
      tick();
      chk("ack_coins", int'({coin2_out, coin1_out}), 0);
      coin_sensed = 1'b1;
      tick();
      coin_sensed = 1'b0;
      chk("ack_rem", int'(remaining), rem_after);
      chk("ack_done", int'(done), last ? 1 : 0);
      if (!last) begin
         chk("gap_busy", int'(busy), 1);
         for (int i = 1; i < GAP_CYC; i++) tick();
         tick();
         chk("gap_coins", int'({coin2_out, coin1_out}), 0);
      end
   endtask

   initial begin
      tick();
      tick();
      chk("rst_coins", int'({coin2_out, coin1_out}), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_fault", int'(fault), 0);
      chk("rst_rem", int'(remaining), 0);
      reset = 1'b1;
      tick();

      // amount 5, hoppers full: 2, 2, 1
      start_pay(5);
      do_coin(2, 3, 1'b0);
      do_coin(2, 1, 1'b0);
      do_coin(1, 0, 1'b1);
      tick();
      chk("t1_idle_busy", int'(busy), 0);
      chk("t1_idle_done", int'(done), 0);
      chk("t1_done_cnt", done_cnt, 1);

      // amount 3, 2-unit hopper empty: three 1-unit coins
      empty2 = 1'b1;
      start_pay(3);
      do_coin(1, 2, 1'b0);
      do_coin(1, 1, 1'b0);
      do_coin(1, 0, 1'b1);
      tick();
      chk("t2_idle_busy", int'(busy), 0);
      empty2 = 1'b0;

      // amount 0: done at N+2, no solenoid activity
      start_pay(0);
      chk("t3_n1_done", int'(done), 0);
      tick();
      chk("t3_n2_done", int'(done), 1);
      chk("t3_n2_coins", int'({coin2_out, coin1_out}), 0);
      tick();
      chk("t3_n3_busy", int'(busy), 0);
      chk("t3_n3_done", int'(done), 0);

      // amount 4, no sense: ack timeout fault
      start_pay(4);
      for (int i = 0; i < PULSE_CYC; i++) begin
         tick();
         chk("t4_pulse_c2", int'(coin2_out), 1);
      end
      for (int i = 0; i < ACK_TIMEOUT; i++) begin
         tick();
         chk("t4_wait_fault", int'(fault), 0);
      end
      tick();
      chk("t4_fault", int'(fault), 1);
      chk("t4_fault_rem", int'(remaining), 4);
      chk("t4_fault_busy", int'(busy), 1);
      chk("t4_fault_coins", int'({coin2_out, coin1_out}), 0);
      amount = 4'd7;
      start = 1'b1;
      coin_sensed = 1'b1;
      tick();
      start = 1'b0;
      coin_sensed = 1'b0;
      tick();
      chk("t4_start_ign", int'(fault), 1);
      chk("t4_rem_frozen", int'(remaining), 4);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t4_clr_fault", int'(fault), 0);
      chk("t4_clr_busy", int'(busy), 0);
      chk("t4_clr_rem", int'(remaining), 4);

      // amount 2, both hoppers empty: fault from SELECT at N+2
      empty2 = 1'b1;
      empty1 = 1'b1;
      start_pay(2);
      tick();
      chk("t5_fault", int'(fault), 1);
      chk("t5_coins", int'({coin2_out, coin1_out}), 0);
      chk("t5_rem", int'(remaining), 2);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t5_clr_busy", int'(busy), 0);
      empty2 = 1'b0;
      empty1 = 1'b0;

      // reset during second coin's pulse, then a clean payout of 1
      start_pay(4);
      do_coin(2, 2, 1'b0);
      tick();
      chk("t6_pulse_c2", int'(coin2_out), 1);
      reset = 1'b0;
      #1;
      chk("t6_rst_coins", int'({coin2_out, coin1_out}), 0);
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_fault", int'(fault), 0);
      chk("t6_rst_rem", int'(remaining), 0);
      #1;
      reset = 1'b1;
      tick();
      chk("t6_idle_busy", int'(busy), 0);
      start_pay(1);
      do_coin(1, 0, 1'b1);
      tick();
      chk("t6_end_busy", int'(busy), 0);

      chk("done_total", done_cnt, 4);
      chk("no_overlap", overlap_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
